// File: rtl/gpr_file_sb.sv
// General-purpose register file: NUM_RD combinational read ports, one write port,
// write-to-read bypass and a per-register pending scoreboard. Optional parity: GPR_PARITY_EN.
module gpr_file_sb #(
  parameter int                DATA_W    = 16,
  parameter int                NUM_REGS  = 8,
  parameter int                ADDR_W    = $clog2(NUM_REGS),
  parameter int                NUM_RD    = 2,
  parameter logic [DATA_W-1:0] RESET_VAL = DATA_W'(1),
  parameter bit                R0_ZERO   = 1'b0,
  parameter bit                BYPASS    = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic                         rsv_en,
  input  logic [ADDR_W-1:0]            rsv_addr,
  input  logic [NUM_RD*ADDR_W-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0]     rd_data,
  output logic [NUM_RD-1:0]            rd_busy,
  output logic [NUM_REGS-1:0]          pend_vec,
  output logic [$clog2(NUM_REGS+1)-1:0] pend_cnt,
  output logic                         rsv_conflict
`ifdef GPR_PARITY_EN
  ,
  output logic [NUM_RD-1:0]            parity_err
`endif
);

  localparam int CNT_W = $clog2(NUM_REGS+1);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                conflict_q, conflict_d;
  logic                wr_ok, rsv_ok, rsv_hit, cnt_inc, cnt_dec;
`ifdef GPR_PARITY_EN
  logic [NUM_REGS-1:0] par_q, par_d;
`endif

  // Addresses beyond NUM_REGS, and reg 0 when hardwired, never touch state.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (32'(a) < 32'(NUM_REGS)) && !(R0_ZERO && (a == '0));
  endfunction

  always_comb begin
    wr_ok  = wr_en && addr_ok(wr_addr);
    rsv_ok = rsv_en && addr_ok(rsv_addr);
    regs_d = regs_q;
    pend_d = pend_q;
`ifdef GPR_PARITY_EN
    par_d  = par_q;
`endif
    if (wr_ok) begin
      regs_d[wr_addr] = wr_data;
      pend_d[wr_addr] = 1'b0;
`ifdef GPR_PARITY_EN
      par_d[wr_addr]  = ^wr_data;
`endif
    end
    // Reservation applied last so a new producer wins over a same-cycle writeback.
    if (rsv_ok) pend_d[rsv_addr] = 1'b1;

    rsv_hit    = rsv_ok && pend_q[rsv_addr] && !(wr_ok && (wr_addr == rsv_addr));
    conflict_d = conflict_q | rsv_hit;
    cnt_inc    = rsv_ok && !pend_q[rsv_addr];
    cnt_dec    = wr_ok && pend_q[wr_addr] && !(rsv_ok && (rsv_addr == wr_addr));
    cnt_d      = cnt_q + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
      pend_q     <= '0;
      cnt_q      <= '0;
      conflict_q <= 1'b0;
`ifdef GPR_PARITY_EN
      par_q      <= {NUM_REGS{^RESET_VAL}};
`endif
    end else begin
      regs_q     <= regs_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      conflict_q <= conflict_d;
`ifdef GPR_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
`ifdef GPR_PARITY_EN
    parity_err = '0;
`endif
    for (int k = 0; k < NUM_RD; k++) begin
      logic [ADDR_W-1:0] ra;
      logic              fwd;
      ra  = rd_addr[k*ADDR_W +: ADDR_W];
      fwd = BYPASS && wr_ok && (wr_addr == ra);
      if (addr_ok(ra)) begin
        if (fwd) begin
          rd_data[k*DATA_W +: DATA_W] = wr_data;
        end else begin
          rd_data[k*DATA_W +: DATA_W] = regs_q[ra];
          rd_busy[k]                  = pend_q[ra];
`ifdef GPR_PARITY_EN
          parity_err[k]               = (^regs_q[ra]) ^ par_q[ra];
`endif
        end
      end
    end
  end

  assign pend_vec     = pend_q;
  assign pend_cnt     = cnt_q;
  assign rsv_conflict = conflict_q;

endmodule

// File: tb/tb_gpr_file_sb.sv
// Bench for gpr_file_sb: default instance plus one with R0_ZERO=1, BYPASS=0, NUM_REGS=6,
// both checked against a rule-level reference model.
module tb_gpr_file_sb;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        wr_en, rsv_en;
  logic [2:0]  wr_addr, rsv_addr;
  logic [15:0] wr_data;
  logic [5:0]  rd_addr;

  logic [31:0] rd_data_a, rd_data_b;
  logic [1:0]  rd_busy_a, rd_busy_b;
  logic [7:0]  pend_vec_a;
  logic [5:0]  pend_vec_b;
  logic [3:0]  pend_cnt_a;
  logic [2:0]  pend_cnt_b;
  logic        conf_a, conf_b;
`ifdef GPR_PARITY_EN
  logic [1:0]  perr_a, perr_b;
`endif

  int checks = 0;
  int errors = 0;

  gpr_file_sb dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rd_addr(rd_addr), .rd_data(rd_data_a),
    .rd_busy(rd_busy_a), .pend_vec(pend_vec_a), .pend_cnt(pend_cnt_a), .rsv_conflict(conf_a)
`ifdef GPR_PARITY_EN
    , .parity_err(perr_a)
`endif
  );

  gpr_file_sb #(.NUM_REGS(6), .R0_ZERO(1'b1), .BYPASS(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .rd_busy(rd_busy_b), .pend_vec(pend_vec_b), .pend_cnt(pend_cnt_b), .rsv_conflict(conf_b)
`ifdef GPR_PARITY_EN
    , .parity_err(perr_b)
`endif
  );

  // Reference model: index 0 = dut_a, index 1 = dut_b
  logic [15:0] mreg  [2][8];
  bit          mpend [2][8];
  bit          mconf [2];

  function automatic int nregs(int i);
    return (i == 0) ? 8 : 6;
  endfunction

  function automatic bit mvalid(int i, int a);
    return (a < nregs(i)) && !(i == 1 && a == 0);
  endfunction

  function automatic logic [15:0] mread(int i, int a);
    if (!mvalid(i, a)) return 16'h0000;
    if (i == 0 && wr_en && int'(wr_addr) == a) return wr_data;
    return mreg[i][a];
  endfunction

  function automatic bit mbusy(int i, int a);
    if (!mvalid(i, a)) return 1'b0;
    if (i == 0 && wr_en && int'(wr_addr) == a) return 1'b0;
    return mpend[i][a];
  endfunction

  function automatic int mcount(int i);
    int n = 0;
    for (int r = 0; r < 8; r++) n += int'(mpend[i][r]);
    return n;
  endfunction

  function automatic logic [7:0] mvec(int i);
    logic [7:0] v = '0;
    for (int r = 0; r < 8; r++) v[r] = mpend[i][r];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mconf[i] = 1'b0;
      for (int r = 0; r < 8; r++) begin
        mreg[i][r]  = 16'h0001;
        mpend[i][r] = 1'b0;
      end
    end
  endtask

  task automatic model_step();
    if (!rst_n) return;
    for (int i = 0; i < 2; i++) begin
      bit wv, rv;
      wv = wr_en && mvalid(i, int'(wr_addr));
      rv = rsv_en && mvalid(i, int'(rsv_addr));
      if (rv && mpend[i][rsv_addr] && !(wv && wr_addr == rsv_addr)) mconf[i] = 1'b1;
      if (wv) begin
        mreg[i][wr_addr]  = wr_data;
        mpend[i][wr_addr] = 1'b0;
      end
      if (rv) mpend[i][rsv_addr] = 1'b1;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; rsv_en = 1'b0; wr_addr = '0; rsv_addr = '0; wr_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    #3;
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    for (int a = 0; a < 8; a++) begin
      logic [15:0] exp_b0, exp_b1;
      rd_addr = {3'(7 - a), 3'(a)};
      exp_b0 = (a == 0 || a >= 6) ? 16'h0000 : 16'h0001;
      exp_b1 = ((7 - a) == 0 || (7 - a) >= 6) ? 16'h0000 : 16'h0001;
      #4;
      checks++;
      if (rd_data_a !== 32'h0001_0001) begin
        errors++; $display("FAIL reset_read_a[%0d]: got %h expected %h", a, rd_data_a, 32'h0001_0001);
      end
      checks++;
      if (rd_data_b !== {exp_b1, exp_b0}) begin
        errors++; $display("FAIL reset_read_b[%0d]: got %h expected %h", a, rd_data_b, {exp_b1, exp_b0});
      end
      cyc();
    end
    checks++;
    if (pend_vec_a !== 8'h00 || pend_cnt_a !== 4'd0 || conf_a !== 1'b0) begin
      errors++; $display("FAIL reset_state_a: got vec=%h cnt=%0d conf=%b expected 00/0/0", pend_vec_a, pend_cnt_a, conf_a);
    end
    checks++;
    if (pend_vec_b !== 6'h00 || pend_cnt_b !== 3'd0 || conf_b !== 1'b0) begin
      errors++; $display("FAIL reset_state_b: got vec=%h cnt=%0d conf=%b expected 00/0/0", pend_vec_b, pend_cnt_b, conf_b);
    end
  endtask

  task automatic test_bypass();
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'hBEEF; rd_addr = {3'd4, 3'd3};
    #4;
    checks++;
    if (rd_data_a !== 32'h0001_BEEF) begin
      errors++; $display("FAIL bypass_same_cycle_a: got %h expected %h", rd_data_a, 32'h0001_BEEF);
    end
    checks++;
    if (rd_data_b[15:0] !== 16'h0001) begin
      errors++; $display("FAIL nobypass_same_cycle_b: got %h expected %h", rd_data_b[15:0], 16'h0001);
    end
    cyc();
    wr_en = 1'b0;
    #4;
    checks++;
    if (rd_data_a[15:0] !== 16'hBEEF || rd_data_b[15:0] !== 16'hBEEF) begin
      errors++; $display("FAIL write_next_cycle: got a=%h b=%h expected beef", rd_data_a[15:0], rd_data_b[15:0]);
    end
    cyc();
  endtask

  task automatic test_scoreboard();
    rsv_en = 1'b1; rsv_addr = 3'd5; rd_addr = {3'd5, 3'd5};
    #4;
    checks++;
    if (rd_busy_a[1] !== 1'b0) begin
      errors++; $display("FAIL busy_before_edge: got %b expected 0", rd_busy_a[1]);
    end
    cyc();
    rsv_en = 1'b0;
    #4;
    checks++;
    if (rd_busy_a[1] !== 1'b1 || rd_busy_b[1] !== 1'b1 || pend_cnt_a !== 4'd1 || pend_vec_a !== 8'h20) begin
      errors++; $display("FAIL reserved: got busy_a=%b busy_b=%b cnt=%0d vec=%h expected 1/1/1/20",
                         rd_busy_a[1], rd_busy_b[1], pend_cnt_a, pend_vec_a);
    end
    cyc();
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h1234;
    #4;
    checks++;
    if (rd_busy_a[1] !== 1'b0 || rd_data_a[31:16] !== 16'h1234 || pend_cnt_a !== 4'd1) begin
      errors++; $display("FAIL wb_bypass_a: got busy=%b data=%h cnt=%0d expected 0/1234/1",
                         rd_busy_a[1], rd_data_a[31:16], pend_cnt_a);
    end
    checks++;
    if (rd_busy_b[1] !== 1'b1 || rd_data_b[31:16] !== 16'h0001) begin
      errors++; $display("FAIL wb_nobypass_b: got busy=%b data=%h expected 1/0001", rd_busy_b[1], rd_data_b[31:16]);
    end
    cyc();
    wr_en = 1'b0;
    #4;
    checks++;
    if (pend_cnt_a !== 4'd0 || pend_cnt_b !== 3'd0 || rd_busy_b[1] !== 1'b0 || rd_data_b[31:16] !== 16'h1234) begin
      errors++; $display("FAIL wb_done: got cnt_a=%0d cnt_b=%0d busy_b=%b data_b=%h expected 0/0/0/1234",
                         pend_cnt_a, pend_cnt_b, rd_busy_b[1], rd_data_b[31:16]);
    end
    cyc();
  endtask

  task automatic test_conflict();
    do_reset();
    rsv_en = 1'b1; rsv_addr = 3'd2;
    cyc();
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h5555;
    cyc();
    idle_inputs();
    #4;
    checks++;
    if (conf_a !== 1'b0 || pend_vec_a !== 8'h04 || pend_cnt_a !== 4'd1) begin
      errors++; $display("FAIL rsv_wr_same_reg: got conf=%b vec=%h cnt=%0d expected 0/04/1", conf_a, pend_vec_a, pend_cnt_a);
    end
    cyc();
    rsv_en = 1'b1; rsv_addr = 3'd2;
    cyc();
    idle_inputs();
    repeat (3) cyc();
    #4;
    checks++;
    if (conf_a !== 1'b1 || conf_b !== 1'b1 || pend_cnt_a !== 4'd1 || pend_vec_a !== 8'h04) begin
      errors++; $display("FAIL conflict_sticky: got conf_a=%b conf_b=%b cnt=%0d vec=%h expected 1/1/1/04",
                         conf_a, conf_b, pend_cnt_a, pend_vec_a);
    end
    cyc();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int r = 1; r <= 4; r++) begin
      rsv_en = 1'b1; rsv_addr = 3'(r);
      wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'($urandom);
      cyc();
    end
    rsv_addr = 3'd5; wr_addr = 3'd6; wr_data = 16'hA5A5; rd_addr = {3'd1, 3'd0};
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (pend_vec_a !== 8'h00 || pend_cnt_a !== 4'd0 || pend_vec_b !== 6'h00 || rd_data_a !== 32'h0001_0001) begin
      errors++; $display("FAIL async_reset: got vec_a=%h cnt_a=%0d vec_b=%h data=%h expected 00/0/00/00010001",
                         pend_vec_a, pend_cnt_a, pend_vec_b, rd_data_a);
    end
    @(posedge clk);
    #1;
    idle_inputs();
    rst_n = 1'b1;
    rd_addr = {3'd6, 3'd5};
    #3;
    checks++;
    if (rd_data_a !== 32'h0001_0001 || rd_busy_a !== 2'b00) begin
      errors++; $display("FAIL inflight_dropped: got data=%h busy=%b expected 00010001/00", rd_data_a, rd_busy_a);
    end
    cyc();
  endtask

  task automatic test_r0_zero();
    do_reset();
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'hFFFF; rsv_en = 1'b1; rsv_addr = 3'd0;
    rd_addr = {3'd0, 3'd0};
    #4;
    checks++;
    if (rd_data_b !== 32'h0 || rd_busy_b !== 2'b00 || rd_data_a[15:0] !== 16'hFFFF) begin
      errors++; $display("FAIL r0_read: got b=%h busy_b=%b a=%h expected 0/00/ffff", rd_data_b, rd_busy_b, rd_data_a[15:0]);
    end
    cyc();
    wr_addr = 3'd7; wr_data = 16'hABCD; rsv_addr = 3'd6;
    cyc();
    rsv_addr = 3'd0; wr_en = 1'b0;
    cyc();
    idle_inputs();
    rd_addr = {3'd7, 3'd0};
    #4;
    checks++;
    if (pend_cnt_b !== 3'd0 || pend_vec_b !== 6'h00 || conf_b !== 1'b0 || rd_data_b !== 32'h0 || rd_busy_b !== 2'b00) begin
      errors++; $display("FAIL r0_oob_ignored: got cnt=%0d vec=%h conf=%b data=%h busy=%b expected 0/00/0/0/00",
                         pend_cnt_b, pend_vec_b, conf_b, rd_data_b, rd_busy_b);
    end
    checks++;
    if (pend_vec_a !== 8'h41 || pend_cnt_a !== 4'd2 || conf_a !== 1'b1 || rd_data_a !== 32'hABCD_FFFF) begin
      errors++; $display("FAIL r0_normal_a: got vec=%h cnt=%0d conf=%b data=%h expected 41/2/1/abcdffff",
                         pend_vec_a, pend_cnt_a, conf_a, rd_data_a);
    end
    cyc();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      wr_en    = 1'($urandom % 2);
      wr_addr  = 3'($urandom % 8);
      wr_data  = 16'($urandom);
      rsv_en   = ($urandom % 3) == 0;
      rsv_addr = 3'($urandom % 8);
      rd_addr  = {3'($urandom % 8), 3'($urandom % 8)};
      if ($urandom % 4 == 0) rd_addr[2:0] = wr_addr;
      #4;
      for (int i = 0; i < 2; i++) begin
        logic [7:0] got_v;
        int         got_c;
        logic       got_f;
        for (int k = 0; k < 2; k++) begin
          int          ra;
          logic [15:0] got_d;
          logic        got_b;
          ra    = int'(rd_addr[k*3 +: 3]);
          got_d = (i == 0) ? rd_data_a[k*16 +: 16] : rd_data_b[k*16 +: 16];
          got_b = (i == 0) ? rd_busy_a[k] : rd_busy_b[k];
          checks++;
          if (got_d !== mread(i, ra)) begin
            errors++; $display("FAIL rand_data i%0d p%0d n%0d: got %h expected %h", i, k, n, got_d, mread(i, ra));
          end
          checks++;
          if (got_b !== mbusy(i, ra)) begin
            errors++; $display("FAIL rand_busy i%0d p%0d n%0d: got %b expected %b", i, k, n, got_b, mbusy(i, ra));
          end
        end
        got_v = (i == 0) ? pend_vec_a : {2'b00, pend_vec_b};
        got_c = (i == 0) ? int'(pend_cnt_a) : int'(pend_cnt_b);
        got_f = (i == 0) ? conf_a : conf_b;
        checks++;
        if (got_v !== mvec(i) || got_c != mcount(i) || got_f !== mconf[i]) begin
          errors++; $display("FAIL rand_pend i%0d n%0d: got vec=%h cnt=%0d conf=%b expected %h/%0d/%b",
                             i, n, got_v, got_c, got_f, mvec(i), mcount(i), mconf[i]);
        end
      end
`ifdef GPR_PARITY_EN
      checks++;
      if (perr_a !== 2'b00 || perr_b !== 2'b00) begin
        errors++; $display("FAIL rand_parity n%0d: got a=%b b=%b expected 00/00", n, perr_a, perr_b);
      end
`endif
      cyc();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rd_addr = '0;
    rst_n   = 1'b0;
    model_reset();
    #12;
    rst_n = 1'b1;
    cyc();
    test_reset();
    test_bypass();
    test_scoreboard();
    test_conflict();
    test_reset_mid();
    test_r0_zero();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
